instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-ROM read interface: owns the PC, drives the ROM index and captures the returned 32-bit instruction.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Honours redirects (branch/jump from EX) by flushing and refetching, and honours a halt request by freezing the PC.
- The ROM is combinational: data for rom_idx_o is valid in the same cycle.

---
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational ROM, and buffers {pc, instr} for decode.
// Head entry is valid 1 cycle after a push; with the buffer full and no pop, the PC stalls and order is preserved.
module instr_fetch_unit #(
    parameter int               PC_LEN     = 32,
    parameter int               INSTR_LEN  = 32,
    parameter logic [PC_LEN-1:0] RST_PC    = 32'h8000_0000,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_LEN-1:0]    rom_idx_o,
    input  logic [INSTR_LEN-1:0] rom_data_i,
    input  logic                 halt_i,
    input  logic                 redirect_i,
    input  logic [PC_LEN-1:0]    redirect_pc_i,
    output logic                 if_valid_o,
    output logic [PC_LEN-1:0]    if_pc_o,
    output logic [INSTR_LEN-1:0] if_instr_o,
    input  logic                 id_ready_i,
    output logic                 misalign_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_LEN-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 misalign_q, misalign_d;
    logic                 push, pop;
    logic                 redir_bit0_unused;

    logic [PC_LEN-1:0]    pc_mem    [FIFO_DEPTH];
    logic [INSTR_LEN-1:0] instr_mem [FIFO_DEPTH];

    assign redir_bit0_unused = redirect_pc_i[0];

    assign if_valid_o = (count_q != '0);
    assign pop        = if_valid_o & id_ready_i & ~redirect_i;
    // A full buffer may still accept a push when the head leaves in the same cycle.
    assign push       = ~redirect_i & ~halt_i & ((count_q < CNT_W'(FIFO_DEPTH)) | pop);

    always_comb begin
        pc_d       = pc_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (redirect_i) begin
            pc_d       = {redirect_pc_i[PC_LEN-1:1], 1'b0};
            rptr_d     = '0;
            wptr_d     = '0;
            count_d    = '0;
            misalign_d = misalign_q | redirect_pc_i[1];
        end else begin
            if (push) begin
                pc_d   = pc_q + PC_LEN'(4);
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RST_PC;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wptr_q]    <= pc_q;
            instr_mem[wptr_q] <= rom_data_i;
        end
    end

    assign rom_idx_o  = pc_q;
    assign if_pc_o    = if_valid_o ? pc_mem[rptr_q]    : '0;
    assign if_instr_o = if_valid_o ? instr_mem[rptr_q] : '0;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, streaming, backpressure, redirect, misalign, halt, PC wrap.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_idx;
    logic [31:0] rom_data;
    logic        halt, redirect, ready;
    logic [31:0] redirect_pc;
    logic        valid, misalign;
    logic [31:0] if_pc, if_instr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        if (a == RST)           return 32'h0000_0293;
        if (a == RST + 32'd4)   return 32'h0000_0313;
        return a ^ 32'h5A5A_0003;
    endfunction

    assign rom_data = rom_f(rom_idx);

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rom_idx_o    (rom_idx),
        .rom_data_i   (rom_data),
        .halt_i       (halt),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .if_valid_o   (valid),
        .if_pc_o      (if_pc),
        .if_instr_o   (if_instr),
        .id_ready_i   (ready),
        .misalign_o   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; ready = 1'b1; redirect_pc = '0;

        // Reset state
        tick(2);
        chk("rst_valid", valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_romidx", rom_idx, RST);
        chk("rst_misalign", misalign, 0);
        rst = 1'b0;

        // Streaming with ready high
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("str_valid", valid, 1);
            chk("str_pc", if_pc, RST + 32'(4 * i));
            chk("str_instr", if_instr, rom_f(RST + 32'(4 * i)));
            chk("str_romidx", rom_idx, RST + 32'(4 * (i + 1)));
        end

        // Backpressure: fill, hold, then drain without gaps
        ready = 1'b0;
        do_reset();
        tick(5);
        chk("bp_valid", valid, 1);
        chk("bp_romidx", rom_idx, RST + 32'd8);
        chk("bp_head", if_pc, RST);
        chk("bp_head_instr", if_instr, 32'h0000_0293);
        ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("bp_drain_valid", valid, 1);
            chk("bp_drain_pc", if_pc, RST + 32'(4 * i));
        end

        // Redirect while full
        ready = 1'b0;
        tick(2);
        chk("rd_full_romidx", rom_idx, RST + 32'h14);
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect = 1'b0; ready = 1'b1;
        chk("rd_valid0", valid, 0);
        chk("rd_romidx", rom_idx, 32'h8000_0100);
        chk("rd_misalign0", misalign, 0);
        tick();
        chk("rd_valid1", valid, 1);
        chk("rd_pc1", if_pc, 32'h8000_0100);
        chk("rd_instr1", if_instr, rom_f(32'h8000_0100));
        tick();
        chk("rd_pc2", if_pc, 32'h8000_0104);

        // Misaligned redirect: bit 0 cleared, sticky flag
        redirect = 1'b1; redirect_pc = 32'h8000_0103;
        tick();
        redirect = 1'b0;
        chk("mis_romidx", rom_idx, 32'h8000_0102);
        chk("mis_flag", misalign, 1);
        tick(10);
        chk("mis_sticky", misalign, 1);
        chk("mis_head", if_pc, 32'h8000_0126);

        // Reset together with a misaligned redirect: reset wins
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000_0203;
        tick();
        rst = 1'b0; redirect = 1'b0;
        chk("rstrd_romidx", rom_idx, RST);
        chk("rstrd_valid", valid, 0);
        chk("rstrd_misalign", misalign, 0);

        // Halt drains the buffer and freezes the PC
        ready = 1'b0;
        tick(2);
        chk("halt_pre_head", if_pc, RST);
        chk("halt_pre_romidx", rom_idx, RST + 32'd8);
        halt = 1'b1; ready = 1'b1;
        tick();
        chk("halt_drain1_valid", valid, 1);
        chk("halt_drain1_pc", if_pc, RST + 32'd4);
        tick();
        chk("halt_empty", valid, 0);
        chk("halt_empty_pc", if_pc, 0);
        tick(3);
        chk("halt_hold_valid", valid, 0);
        chk("halt_hold_romidx", rom_idx, RST + 32'd8);
        halt = 1'b0;
        tick();
        chk("halt_resume_valid", valid, 1);
        chk("halt_resume_pc", if_pc, RST + 32'd8);
        chk("halt_resume_romidx", rom_idx, RST + 32'hC);

        // PC wraps silently from 0xFFFFFFFC to 0
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_romidx0", rom_idx, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        chk("wrap_romidx1", rom_idx, 32'h0);
        tick();
        chk("wrap_pc1", if_pc, 32'h0);
        chk("wrap_instr1", if_instr, rom_f(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
